// File: rtl/weight_bank_loader.sv
// ---------------------------------------------------------------------------
// WeightBankLoader
//
// Purpose:
//   Streams NUM*DEPTH weight words from a valid/ready input into NUM weight
//   banks. Words are interleaved across banks: word k goes to bank k mod NUM
//   at address k div NUM. A load starts with a one-cycle start pulse in IDLE
//   and ends with a one-cycle done pulse that lines up with the final write.
//
// Ports:
//   clk       - single clock, all logic on the rising edge
//   rst       - synchronous, active-high reset
//   start     - one-cycle request to begin a load (honoured only in IDLE)
//   in_data   - incoming weight word (WIDTH bits)
//   in_valid  - in_data is valid this cycle
//   in_ready  - loader accepts a word this cycle (state is LOAD)
//   wr_en     - one-hot bank write strobe, bit i targets bank i (NUM bits)
//   wr_addr   - bank write address (ADDR bits)
//   wr_data   - bank write data (WIDTH bits)
//   busy      - high while a load is in progress
//   done      - one-cycle pulse coinciding with the final bank write
// ---------------------------------------------------------------------------
module weight_bank_loader #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 10,
    parameter int NUM   = 3,
    parameter int DEPTH = 736
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NUM-1:0]   wr_en,
    output logic [ADDR-1:0]  wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done
);

    // A single bank still needs a one-bit counter so the vectors stay legal.
    localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [BW-1:0]   LAST_BANK = BW'(NUM - 1);
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bank_q, bank_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [NUM-1:0]   wr_en_q, wr_en_d;
    logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

    logic accept;
    logic lastWord;

    // A word moves only when the registered state says LOAD and the source
    // offers data; ready never looks at valid, so there is no comb loop.
    assign accept   = in_valid && (state_q == S_LOAD);
    assign lastWord = (bank_q == LAST_BANK) && (addr_q == LAST_ADDR);

    // State register. Reset forces IDLE regardless of start or in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so a start during
    // LOAD or in the DONE cycle has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)               state_d = S_LOAD;
            S_LOAD:  if (accept && lastWord)  state_d = S_DONE;
            S_DONE:                           state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Output decode, purely from the registered state.
    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q == S_LOAD);
        done     = (state_q == S_DONE);
    end

    // Bank/address counters. The bank counter runs fastest so consecutive
    // words land in consecutive banks at the same address. After the final
    // word the address wraps to 0 so it never reaches DEPTH.
    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        if (state_q == S_IDLE && start) begin
            bank_d = '0;
            addr_d = '0;
        end else if (accept) begin
            if (bank_q == LAST_BANK) begin
                bank_d = '0;
                addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR'(1);
            end else begin
                bank_d = bank_q + BW'(1);
            end
        end
    end

    // Write port next values. The strobe is a one-cycle pulse following an
    // acceptance; address and data hold between writes.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_en_d   = NUM'(1) << bank_q;
            wr_addr_d = addr_q;
            wr_data_d = in_data;
        end
    end

    // Datapath registers. Reset clears everything, which also guarantees no
    // stray strobe in the cycle after a mid-load abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q    <= '0;
            addr_q    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_weight_bank_loader.sv
// ---------------------------------------------------------------------------
// TbWeightBankLoader
//
// Purpose:
//   Self-checking bench for weight_bank_loader with NUM=3, DEPTH=4. A
//   stimulus process drives directed scenarios followed by a randomized
//   phase. A reference model watches the same inputs, counts accepted words
//   and pushes the expected bank write into a queue; a separate monitor pops
//   that queue whenever a write is due and compares the DUT outputs.
// ---------------------------------------------------------------------------
module tb_weight_bank_loader;

    localparam int WIDTH = 16;
    localparam int ADDR  = 10;
    localparam int NUM   = 3;
    localparam int DEPTH = 4;
    localparam int TOTAL = NUM * DEPTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NUM-1:0]   wr_en;
    logic [ADDR-1:0]  wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    typedef enum int {M_IDLE, M_LOAD, M_DONE} mstate_t;

    typedef struct {
        int          bank;
        int          addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    wr_t     expQ[$];
    wr_t     monW;
    mstate_t mState = M_IDLE;
    int      wordCount = 0;
    int      expAddr = 0;
    int      expData = 0;

    weight_bank_loader #(
        .WIDTH(WIDTH),
        .ADDR (ADDR),
        .NUM  (NUM),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, changing them on the falling edge so they
    // are stable at the rising edge where both DUT and model sample them.
    task automatic applyStimulus(input bit s, input bit v, input logic [15:0] d, input bit r);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
        rst      = r;
    endtask

    // Reference model: a load is a count of accepted words. Word k goes to
    // bank k mod NUM at address k div NUM; after TOTAL words the load
    // finishes with one DONE cycle before returning to idle.
    always @(posedge clk) begin
        if (rst) begin
            mState    = M_IDLE;
            wordCount = 0;
            expAddr   = 0;
            expData   = 0;
            expQ.delete();
        end else begin
            case (mState)
                M_IDLE: begin
                    if (start) begin
                        mState    = M_LOAD;
                        wordCount = 0;
                    end
                end
                M_LOAD: begin
                    if (in_valid) begin
                        wr_t w;
                        w.bank = wordCount % NUM;
                        w.addr = wordCount / NUM;
                        w.data = in_data;
                        w.last = (wordCount == TOTAL - 1);
                        expQ.push_back(w);
                        expAddr = w.addr;
                        expData = int'(in_data);
                        wordCount++;
                        if (wordCount == TOTAL) mState = M_DONE;
                    end
                end
                default: mState = M_IDLE;
            endcase
        end
    end

    // Monitor: shortly after each rising edge compare status outputs with
    // the model and, whenever a write is due or seen, pop the scoreboard.
    always @(posedge clk) begin
        #1;
        checkOutput("in_ready", int'(in_ready), int'(mState == M_LOAD));
        checkOutput("busy", int'(busy), int'(mState == M_LOAD));
        checkOutput("done", int'(done), int'(mState == M_DONE));
        if (wr_en != '0 || expQ.size() > 0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_wr_en", int'(wr_en), 0);
            end else begin
                monW = expQ.pop_front();
                checkOutput("wr_en", int'(wr_en), 1 << monW.bank);
                checkOutput("wr_addr", int'(wr_addr), monW.addr);
                checkOutput("wr_data", int'(wr_data), int'(monW.data));
                checkOutput("done_with_last", int'(done), int'(monW.last));
            end
        end
        checkOutput("wr_addr_hold", int'(wr_addr), expAddr);
        checkOutput("wr_data_hold", int'(wr_data), expData);
    end

    // Scenario sequence: directed cases first, then a randomized soak.
    initial begin
        $display("[TB] starting weight_bank_loader bench");

        // Reset for a few cycles.
        repeat (3) applyStimulus(0, 0, 16'h0, 1);

        // Idle stimulus: valid data with no start must never be written.
        repeat (5) applyStimulus(0, 1, 16'hBEEF, 0);

        // Continuous stream, then valid held high after completion.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < TOTAL; i++) applyStimulus(0, 1, 16'(16'h1000 + i), 0);
        repeat (3) applyStimulus(0, 1, 16'hDEAD, 0);
        applyStimulus(0, 0, 16'h0, 0);

        // Bubbles: valid alternates, writes must match the continuous case.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < 2 * TOTAL; i++) applyStimulus(0, (i % 2) == 0, 16'(16'h2000 + i), 0);
        repeat (2) applyStimulus(0, 0, 16'h0, 0);

        // Start pulsed during the load at word 5 must be ignored.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < TOTAL; i++) applyStimulus(i == 5, 1, 16'(16'h3000 + i), 0);
        repeat (2) applyStimulus(0, 0, 16'h0, 0);

        // Reset after word 6, then a full restart from bank 0, addr 0.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 16'(16'h4000 + i), 0);
        applyStimulus(0, 1, 16'h4FFF, 1);
        applyStimulus(0, 0, 16'h0, 0);
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < TOTAL; i++) applyStimulus(0, 1, 16'(16'h5000 + i), 0);
        repeat (2) applyStimulus(0, 0, 16'h0, 0);

        // Back-to-back: start in the DONE cycle is ignored, the next one wins.
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < TOTAL; i++) applyStimulus(0, 1, 16'(16'h6000 + i), 0);
        applyStimulus(1, 1, 16'h6EEE, 0);
        applyStimulus(1, 0, 16'h0, 0);
        for (int i = 0; i < TOTAL; i++) applyStimulus(0, 1, 16'(16'h7000 + i), 0);
        repeat (2) applyStimulus(0, 0, 16'h0, 0);

        // Randomized soak: sporadic starts, gappy valid, rare resets.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0,
                          16'($urandom),
                          $urandom_range(0, 199) == 0);
        end

        // Drain and confirm every expected write was observed.
        repeat (4) applyStimulus(0, 0, 16'h0, 0);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/weight_bank_loader.md
WEIGHT_BANK_LOADER -- requirements
Module: weight_bank_loader

Interface
REQ-001 Parameter WIDTH, default 16, bits per weight word.
REQ-002 Parameter ADDR, default 10, bank address width.
REQ-003 Parameter NUM, default 3, number of weight banks.
REQ-004 Parameter DEPTH, default 736, words loaded per bank; legal range 1..2**ADDR.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load.
REQ-008 in_data  input  WIDTH  incoming weight word.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 wr_en  output  NUM  one-hot bank write strobe, bit i targets bank i.
REQ-012 wr_addr  output  ADDR  bank write address.
REQ-013 wr_data  output  WIDTH  bank write data.
REQ-014 busy  output  1  high while in LOAD.
REQ-015 done  output  1  one-cycle pulse after the final word is written.

Function
REQ-016 FSM states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on acceptance of the final word; DONE->IDLE unconditionally after one cycle.
REQ-017 start shall be ignored in LOAD and DONE.
REQ-018 On IDLE->LOAD, the bank counter (0..NUM-1) and the address counter (0..DEPTH-1) shall clear to 0.
REQ-019 in_ready shall equal (state==LOAD), decoded from the registered state, with no combinational dependence on in_valid.
REQ-020 A word is accepted on any cycle with in_valid && in_ready; no other cycle advances the counters.
REQ-021 Accepted word k, counting from 0, shall go to bank k mod NUM at address k div NUM (interleaved ordering).
REQ-022 Write latency is one cycle: in the cycle after acceptance, wr_en has only the bit for the current bank set, and wr_addr and wr_data are registered copies.
REQ-023 wr_en shall be all-zero in every cycle not following an acceptance; wr_addr and wr_data hold their last value.
REQ-024 After each acceptance the bank counter increments; on reaching NUM-1 it wraps to 0 and the address counter increments.
REQ-025 The final word is the one with bank NUM-1 and address DEPTH-1; total words per load = NUM*DEPTH.
REQ-026 in_ready shall be 0 from the cycle after the final acceptance; in_valid held high after that point has no effect.
REQ-027 done shall be high for exactly the single cycle in DONE, which coincides with the final wr_en pulse.
REQ-028 busy shall equal (state==LOAD).
REQ-029 The counters shall never reach an address >= DEPTH or a bank >= NUM.
REQ-030 A start asserted in the DONE cycle shall be ignored; a new load requires start in IDLE.

Reset
REQ-031 While rst=1: state=IDLE, counters=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-032 rst takes priority over start and in_valid in the same cycle.
REQ-033 rst during LOAD shall abort the load: partially written banks are left as is, no done pulse, and no wr_en in the cycle after reset.

Verification (NUM=3, DEPTH=4, WIDTH=16, ADDR=10)
REQ-034 Continuous stream: start, then words 0..11 with in_valid=1 every cycle -> wr_en sequence 001,010,100 repeating with wr_addr 0,0,0,1,1,1,...,3,3,3; word 11 lands in bank 2 at addr 3; done high in the same cycle as the last wr_en; in_ready low from the next cycle.
REQ-035 Bubbles: in_valid toggled 1,0,1,0 across the load -> writes are identical to REQ-034 in order and content, and wr_en=0 in the cycles following in_valid=0.
REQ-036 Idle stimulus: in_valid=1 with in_data=0xBEEF and no start -> in_ready=0 and wr_en never asserts.
REQ-037 Start ignored: start pulsed at word 5 of a load -> counters are unaffected and the load completes after 12 words with a single done pulse.
REQ-038 Reset mid-load: rst for one cycle after word 6 -> all outputs 0 the next cycle; a following start plus 12 words restarts at bank 0, addr 0.
REQ-039 Back-to-back loads: start in the DONE cycle is ignored; start one cycle later begins a second load from bank 0, addr 0.
